// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, prefetch FIFO,
// stall/redirect handling and NOP bubble injection toward the core.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          CLOCK,
  input  logic          RST,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          stall_in,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instr,
  output logic [31:0]   PC,
  output logic          instr_valid,
  output logic [1:0]    dbg_state_o,
  output logic [CW-1:0] dbg_count_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  redirect_aligned;
  logic         push, pop, full, empty;
  logic [63:0]  head;
  fetch_entry_t head_e;
  logic [CW-1:0] count;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign head_e           = fetch_entry_t'(head);

  assign imem_req  = (state_q == REQ) && !full && !redirect && !RST;
  assign imem_addr = fetch_pc_q;

  assign instr_valid = !empty;
  assign instr       = empty ? NOP_INSTR : head_e.instr;
  assign PC          = empty ? 32'h0 : head_e.pc;
  assign pop         = instr_valid && !stall_in && !redirect;

  assign dbg_state_o = state_q;
  assign dbg_count_o = count;

  // Handshake: imem_req is a one-cycle strobe issued only from REQ; exactly one
  // imem_rvalid strobe is expected per request, consumed in WAIT (kept) or DRAIN
  // (dropped). The core consumes the head whenever instr_valid && !stall_in.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    case (state_q)
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_aligned;
        end else if (imem_req) begin
          req_pc_d = fetch_pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_aligned;
          state_d    = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        // A response arriving with a redirect still retires the stale request.
        if (redirect) fetch_pc_d = redirect_aligned;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk_i   (CLOCK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  ({req_pc_q, imem_rdata}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        req_lo, req_hi, valid_lo, valid_hi;
  logic [31:0] addr_lo, addr_hi, instr_lo, instr_hi, pc_lo, pc_hi;
  logic [1:0]  st_lo, st_hi;
  logic [1:0]  cnt_lo, cnt_hi;

  always #5 CLOCK = ~CLOCK;

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h00000000)) u_dut (
    .CLOCK(CLOCK), .RST(RST), .imem_req(req_lo), .imem_addr(addr_lo),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_in(stall_in),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr_lo), .PC(pc_lo),
    .instr_valid(valid_lo), .dbg_state_o(st_lo), .dbg_count_o(cnt_lo)
  );

  fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFFFFF8)) u_dut_hi (
    .CLOCK(CLOCK), .RST(RST), .imem_req(req_hi), .imem_addr(addr_hi),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_in(stall_in),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr_hi), .PC(pc_hi),
    .instr_valid(valid_hi), .dbg_state_o(st_hi), .dbg_count_o(cnt_hi)
  );

  typedef struct {
    int          lat;
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, instr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          resp_cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = '0;
  logic        use_hi = 1'b0;
  vec_t        tbl[$];

  function automatic logic [31:0] md(logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  // Row builder: inputs, then expected imem_req/addr and head (valid implies instr=md(pc)).
  function automatic vec_t mk(int lat, logic rst, logic stall, logic redir, logic [31:0] rpc,
                              logic chk, logic req, logic [31:0] addr, logic valid,
                              logic [31:0] pc);
    vec_t v;
    v.lat = lat; v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.chk = chk; v.req = req; v.addr = addr; v.valid = valid;
    v.pc    = valid ? pc : 32'h0;
    v.instr = valid ? md(pc) : NOP_INSTR;
    return v;
  endfunction

  task automatic chk32(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply_row(vec_t v, string tag, int idx);
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_instr;
    mem_lat = v.lat;
    @(posedge CLOCK); #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (last_req) begin
      pend = 1'b1; pend_addr = last_addr; resp_cyc = cyc + mem_lat - 1;
    end
    if (pend && cyc == resp_cyc) begin
      imem_rvalid = 1'b1; imem_rdata = md(pend_addr); pend = 1'b0;
    end
    RST = v.rst; stall_in = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    @(negedge CLOCK);
    o_req   = use_hi ? req_hi   : req_lo;
    o_addr  = use_hi ? addr_hi  : addr_lo;
    o_valid = use_hi ? valid_hi : valid_lo;
    o_pc    = use_hi ? pc_hi    : pc_lo;
    o_instr = use_hi ? instr_hi : instr_lo;
    chk32({tag, ".imem_req"}, idx, {31'b0, o_req}, {31'b0, v.req});
    if (v.req) chk32({tag, ".imem_addr"}, idx, o_addr, v.addr);
    if (v.chk) begin
      chk32({tag, ".instr_valid"}, idx, {31'b0, o_valid}, {31'b0, v.valid});
      chk32({tag, ".PC"}, idx, o_pc, v.pc);
      chk32({tag, ".instr"}, idx, o_instr, v.instr);
    end
    last_req  = o_req;
    last_addr = o_addr;
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], tag, i);
    tbl.delete();
  endtask

  task automatic push_reset();
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
  endtask

  initial begin
    // Sequential fetch, then a 10-cycle stall with a full FIFO, then release.
    push_reset();
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h4,  1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 32'h8,  1, 32'h4));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 32'h4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,      1, 32'h4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hC,  1, 32'h8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h10, 1, 32'hC));
    run_table("seq_stall");

    // Redirect while waiting on a late (3-cycle) response.
    push_reset();
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h0,   0, 0));
    tbl.push_back(mk(3, 0, 0, 1, 32'h100,    1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h104, 1, 32'h100));
    run_table("redir_late");

    // Redirect to a misaligned target in the same cycle as the response.
    push_reset();
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h203,    1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 0, 0,       0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,          1, 1, 32'h204, 1, 32'h200));
    run_table("redir_rvalid");

    // Address wrap from RESET_PC = 0xFFFFFFF8 on the second instance.
    use_hi = 1'b1;
    push_reset();
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hFFFFFFF8, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFF8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h00000000, 1, 32'hFFFFFFFC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h00000004, 1, 32'h00000000));
    run_table("wrap");
    use_hi = 1'b0;

    // Reset pulse while waiting; the stale response lands in REQ and is ignored.
    push_reset();
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h4, 1, 32'h0));
    run_table("rst_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the pipelined core and drives its `instr` and `PC` inputs.
- Generates sequential fetch addresses and talks to instruction memory through a single-outstanding request/response handshake.
- Buffers fetched words in a small prefetch FIFO and presents them to the core's IF/ID register.
- Honours core stall and branch/jump redirect; injects NOP bubbles whenever no valid instruction is available.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- imem_req  output  1  request strobe; one cycle per request.
- imem_addr  output  32  fetch address, valid while imem_req=1.
- imem_rvalid  input  1  response strobe; one cycle.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- stall_in  input  1  core cannot accept an instruction this cycle.
- redirect  input  1  taken branch/jal/jalr; flush and refetch.
- redirect_pc  input  32  new fetch address, valid with redirect.
- instr  output  32  instruction to core; NOP_INSTR when instr_valid=0.
- PC  output  32  address of `instr`; 0 when instr_valid=0.
- instr_valid  output  1  `instr`/`PC` hold a real fetched instruction.

Behaviour:
- Reset (RST=1 at clock edge):
  - fetch_pc <= RESET_PC; FIFO emptied; state <= REQ.
  - Outputs: imem_req=0, instr=NOP_INSTR (32'h00000013), PC=0, instr_valid=0.
- States: REQ, WAIT, DRAIN.
- REQ:
  - imem_req = (count < DEPTH) && !redirect && !RST (combinational); imem_addr = fetch_pc.
  - When imem_req=1: latch req_pc <= fetch_pc, go to WAIT.
  - FIFO full: no request issued; stay in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {req_pc, imem_rdata}; fetch_pc <= fetch_pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0); go to REQ.
- DRAIN:
  - imem_req=0.
  - On imem_rvalid: discard the data; go to REQ.
- Space is always guaranteed for the single in-flight response, because a request is only issued when count < DEPTH.
- Output side:
  - instr/PC/instr_valid reflect the FIFO head combinationally.
  - Pop when instr_valid && !stall_in && !redirect.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Latency: a response pushed at edge N appears as instr_valid=1 in the cycle after edge N. Minimum from reset release to first valid instruction is 2 cycles, given a 1-cycle memory.
- Stall: head is held stable; fetching continues until the FIFO is full.
- Redirect (priority over stall and over all fetch activity):
  - FIFO flushed; instr_valid=0 from the next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In REQ: stay in REQ; no request issued in the redirect cycle.
  - In WAIT, no rvalid this cycle: go to DRAIN.
  - In WAIT, rvalid in the same cycle: response discarded; go to REQ.
  - In DRAIN: fetch_pc updated; stay in DRAIN.
- imem_rvalid in REQ is a protocol error and is ignored (no push).
- RST asserted mid-transaction: all state cleared; the next imem_rvalid arrives in REQ and is ignored.
- count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Decomposition:
- Package fetch_pkg holds NOP_INSTR = 32'h00000013 and the typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t.
- Sub-module fetch_fifo is a synchronous FIFO of 64-bit {pc, instr} entries with push, pop, flush, full, empty and count. Flush has priority over push.

Test Plan:
- Reset, 1-cycle memory returning word = addr^32'hA5A5A5A5, stall_in=0 → addresses 0,4,8,… requested; instr_valid rises 2 cycles after RST falls; PC sequence 0,4,8 with matching instr.
- stall_in=1 for 10 cycles → imem_req stops after exactly 2 accepted responses (DEPTH=2); head stays PC=0x4 throughout; after release, PC=0x4 then 0x8 with no gap.
- Redirect to 0x100 while in WAIT with response 3 cycles late → late word dropped; next request addr=0x100; first valid PC=0x100; no instr from before the redirect is ever presented.
- Redirect with redirect_pc=0x203 in the same cycle as imem_rvalid → response dropped; next imem_addr=0x200.
- RESET_PC=32'hFFFFFFF8, no stall → PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- RST pulsed while in WAIT, response arriving the cycle after → no push; outputs are NOP/0/0; next request addr=RESET_PC.
